// File: rtl/argmax_8.sv
// Streaming argmax over N signed elements.
// Collects one vector, then holds max value and index until taken.
module argmax_8 #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [IDXW-1:0]  idx_out
);

  typedef enum logic {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  state_t            state_q;
  state_t            state_d;
  logic [IDXW-1:0]   cnt_q;
  logic [IDXW-1:0]   cnt_d;
  logic [WIDTH-1:0]  max_q;
  logic [WIDTH-1:0]  max_d;
  logic [IDXW-1:0]   idx_q;
  logic [IDXW-1:0]   idx_d;
  logic              accept;
  logic              first;
  logic              last;
  logic              greater;

  assign s_ready = (state_q == COLLECT);
  assign m_valid = (state_q == RESULT);
  assign accept  = s_valid & s_ready;
  assign first   = (cnt_q == '0);
  assign last    = (cnt_q == LAST);
  assign greater = $signed(data_in) > $signed(max_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          // Strict > keeps the earlier index on ties
          if (first || greater) begin
            max_d = data_in;
            idx_d = cnt_q;
          end
          if (last) begin
            cnt_d   = '0;
            state_d = RESULT;
          end else begin
            cnt_d = cnt_q + IDXW'(1);
          end
        end
      end
      RESULT: begin
        if (m_ready) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign data_out = max_q;
  assign idx_out  = idx_q;

endmodule

// File: tb/tb_argmax_8.sv
// Directed and randomised checks for argmax_8.
// Inputs change on the falling edge; outputs sampled there too.
module tb_argmax_8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0;
  logic              m_ready = 1'b1;
  logic signed [7:0] data_in = '0;
  logic              s_ready;
  logic              m_valid;
  logic signed [7:0] data_out;
  logic [2:0]        idx_out;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  logic [10:0] res_q[$];
  int res_acc[$];

  argmax_8 #(.N(8), .WIDTH(8), .IDXW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .idx_out  (idx_out)
  );

  always #5 clk = ~clk;

  // Record accepts and result handshakes as seen at the edge
  always @(posedge clk) begin
    if (reset) begin
      if (s_valid && s_ready) acc_cnt++;
      if (m_valid && m_ready) begin
        res_q.push_back({data_out, idx_out});
        res_acc.push_back(acc_cnt);
      end
    end
  end

  task automatic push(input logic signed [7:0] v[8],
                      input int gap, output int cyc);
    int i;
    i = 0;
    cyc = 0;
    while (i < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (gap > 0 && $urandom_range(99) < gap) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        data_in = v[i];
        if (s_ready) i++;
      end
    end
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (res_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: s_ready=%b m_valid=%b expected 1 0",
               s_ready, m_valid);
    end
    checks++;
    if (data_out !== 8'sd0 || idx_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_out: data=%0d idx=%0d expected 0 0",
               data_out, idx_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: s_ready=%b m_valid=%b expected 1 0",
               s_ready, m_valid);
    end
  endtask

  task automatic test_basic;
    logic signed [7:0] v[8];
    int cyc;
    v = '{8'sd3, 8'sd9, 8'sd1, 8'sd0, 8'sd9, 8'sd2, 8'sd7, 8'sd4};
    m_ready = 1'b1;
    res_q.delete();
    res_acc.delete();
    push(v, 0, cyc);
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early: m_valid=%b expected 0", m_valid);
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_lat: m_valid=%b s_ready=%b expected 1 0",
               m_valid, s_ready);
    end
    checks++;
    if (data_out !== 8'sd9 || idx_out !== 3'd1) begin
      failures++;
      $display("FAIL basic_val: data=%0d idx=%0d expected 9 1",
               data_out, idx_out);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_ret: m_valid=%b s_ready=%b expected 0 1",
               m_valid, s_ready);
    end
  endtask

  task automatic test_negative;
    logic signed [7:0] v[8];
    int cyc;
    v = '{-8'sd5, -8'sd2, -8'sd8, -8'sd3, -8'sd2, -8'sd7, -8'sd1, -8'sd6};
    m_ready = 1'b0;
    push(v, 0, cyc);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (m_valid !== 1'b1 || data_out !== -8'sd1 || idx_out !== 3'd6) begin
      failures++;
      $display("FAIL neg: v=%b data=%0d idx=%0d expected 1 -1 6",
               m_valid, data_out, idx_out);
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    logic signed [7:0] v[8];
    int cyc;
    int base;
    bit ok;
    v = '{8'sd10, -8'sd3, 8'sd25, 8'sd25, 8'sd7, 8'sd0, -8'sd128, 8'sd24};
    res_q.delete();
    res_acc.delete();
    m_ready = 1'b0;
    push(v, 0, cyc);
    @(negedge clk);
    base = acc_cnt;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 ||
          data_out !== 8'sd25 || idx_out !== 3'd2) begin
        failures++;
        $display("FAIL stall_%0d: v=%b r=%b data=%0d idx=%0d exp 1 0 25 2",
                 k, m_valid, s_ready, data_out, idx_out);
      end
      s_valid = (k % 2 == 0);
      data_in = 8'sd127;
      @(negedge clk);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || acc_cnt != base) begin
      failures++;
      $display("FAIL stall_ret: v=%b r=%b acc=%0d expected 0 1 %0d",
               m_valid, s_ready, acc_cnt, base);
    end
    checks++;
    if (res_q.size() != 1 || res_q[0] !== {8'sd25, 3'd2}) begin
      failures++;
      $display("FAIL stall_once: results=%0d expected 1", res_q.size());
    end
    res_q.delete();
    res_acc.delete();
    v = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd0};
    push(v, 0, cyc);
    @(negedge clk);
    s_valid = 1'b0;
    wait_res(ok);
    checks++;
    if (!ok || res_q[0] !== {8'sd7, 3'd6}) begin
      failures++;
      $display("FAIL stall_next: ok=%0d res=%h expected 1 %h",
               ok, ok ? res_q[0] : 11'h0, {8'sd7, 3'd6});
    end
  endtask

  task automatic test_async_reset;
    logic signed [7:0] v[8];
    int cyc;
    int base;
    bit ok;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      data_in = 8'sd50;
    end
    @(negedge clk);
    s_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 ||
        data_out !== 8'sd0 || idx_out !== 3'd0) begin
      failures++;
      $display("FAIL arst: r=%b v=%b data=%0d idx=%0d expected 1 0 0 0",
               s_ready, m_valid, data_out, idx_out);
    end
    @(negedge clk);
    reset = 1'b1;
    res_q.delete();
    res_acc.delete();
    base = acc_cnt;
    v = '{8'sd1, -8'sd1, 8'sd2, -8'sd2, 8'sd3, -8'sd3, 8'sd4, -8'sd4};
    push(v, 0, cyc);
    @(negedge clk);
    s_valid = 1'b0;
    wait_res(ok);
    checks++;
    if (!ok || res_q[0] !== {8'sd4, 3'd6} || res_acc[0] - base != 8) begin
      failures++;
      $display("FAIL arst_fresh: ok=%0d res=%h expected %h",
               ok, ok ? res_q[0] : 11'h0, {8'sd4, 3'd6});
    end
  endtask

  task automatic test_back_to_back;
    logic signed [7:0] a[8];
    logic signed [7:0] b[8];
    int c1;
    int c2;
    int base;
    m_ready = 1'b1;
    res_q.delete();
    res_acc.delete();
    base = acc_cnt;
    a = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    b = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
    push(a, 0, c1);
    push(b, 0, c2);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (c1 + c2 != 17) begin
      failures++;
      $display("FAIL b2b_cycles: got %0d expected 17", c1 + c2);
    end
    checks++;
    if (res_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 2", res_q.size());
    end else begin
      checks++;
      if (res_q[0] !== {8'sd0, 3'd0} || res_q[1] !== {8'sd8, 3'd7}) begin
        failures++;
        $display("FAIL b2b_val: got %h %h expected %h %h", res_q[0],
                 res_q[1], {8'sd0, 3'd0}, {8'sd8, 3'd7});
      end
      checks++;
      if (res_acc[0] - base != 8 || res_acc[1] - base != 16) begin
        failures++;
        $display("FAIL b2b_acc: got %0d %0d expected 8 16",
                 res_acc[0] - base, res_acc[1] - base);
      end
    end
  endtask

  task automatic test_random;
    logic signed [7:0] v[8];
    logic signed [7:0] emax;
    logic [2:0] eidx;
    int cyc;
    int base;
    bit ok;
    m_ready = 1'b1;
    res_q.delete();
    res_acc.delete();
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(255));
      if (n % 10 == 0) v[5] = v[1];
      emax = v[0];
      eidx = 3'd0;
      for (int i = 1; i < 8; i++) begin
        if (v[i] > emax) begin
          emax = v[i];
          eidx = 3'(i);
        end
      end
      base = acc_cnt;
      push(v, 50, cyc);
      @(negedge clk);
      s_valid = 1'b0;
      wait_res(ok);
      checks++;
      if (!ok || res_q[0] !== {emax, eidx} || res_acc[0] - base != 8) begin
        failures++;
        $display("FAIL rand_%0d: ok=%0d res=%h expected %h", n, ok,
                 ok ? res_q[0] : 11'h0, {emax, eidx});
      end
      res_q.delete();
      res_acc.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/argmax_8.md
ARGMAX_8 -- requirements
Module: argmax_8

Interface
REQ-001 SHALL have parameter N, default 8, number of elements per input vector (one output vector of the upstream layer).
REQ-002 SHALL have parameter WIDTH, default 8, element bit width, two's complement signed.
REQ-003 SHALL have parameter IDXW, default 3, index width, equal to ceil(log2(N)).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port s_valid, input, 1, upstream element valid.
REQ-007 SHALL have port s_ready, output, 1, block accepts an element this cycle.
REQ-008 SHALL have port data_in, input, WIDTH, signed element from the upstream layer.
REQ-009 SHALL have port m_valid, output, 1, result valid.
REQ-010 SHALL have port m_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port data_out, output, WIDTH, signed maximum element value of the vector.
REQ-012 SHALL have port idx_out, output, IDXW, position (0..N-1) of the maximum element in arrival order.

Function
REQ-013 SHALL implement states COLLECT and RESULT.
REQ-014 SHALL assert s_ready=1 in COLLECT and s_ready=0 in RESULT; s_ready is a registered state decode, not dependent on s_valid.
REQ-015 SHALL accept an element only on a rising edge where s_valid=1 and s_ready=1; s_valid=0 cycles leave all state unchanged.
REQ-016 SHALL hold an element counter 0..N-1, incremented per accepted element.
REQ-017 SHALL, for the element accepted at count 0, load it as the running max and load index 0 unconditionally.
REQ-018 SHALL, for elements at count 1..N-1, replace the running max and index only if data_in > running max under signed comparison; ties keep the earlier, lower index.
REQ-019 SHALL, on accepting the element at count N-1, enter RESULT on that edge, wrap the counter to 0, and apply the REQ-018 update on the same edge.
REQ-020 SHALL assert m_valid=1 exactly in RESULT, so the result is valid in the cycle after the last element is accepted; latency is 1 cycle.
REQ-021 SHALL drive data_out and idx_out from the running max and index registers.
REQ-022 SHALL keep data_out and idx_out stable while m_valid=1 and m_ready=0, for any number of cycles.
REQ-023 SHALL, on an edge in RESULT with m_ready=1, return to COLLECT; s_ready=1 and m_valid=0 from the next cycle.
REQ-024 SHALL NOT accept input in the cycle of the result handshake; s_valid asserted then is held by the upstream and taken the following cycle.
REQ-025 SHALL ignore m_ready while in COLLECT.
REQ-026 SHALL treat data_out and idx_out as don't-care in COLLECT.
REQ-027 SHALL process back-to-back vectors without gaps beyond the 1-cycle RESULT minimum, giving a maximum throughput of N elements per N+1 cycles.

Reset
REQ-028 SHALL, while reset=0, asynchronously force COLLECT, counter=0, s_ready=1, m_valid=0, data_out=0 and idx_out=0.
REQ-029 SHALL discard a partially collected vector or a pending unaccepted result if reset asserts mid-operation; the first element accepted after release is element 0.
REQ-030 SHALL resume operation on the first rising clk edge after reset returns to 1.

Verification
REQ-031 Continuous s_valid with vector [3,9,1,0,9,2,7,4] and m_ready=1 -> m_valid pulses the cycle after the 8th accept, data_out=9, idx_out=1 (tie keeps lower index).
REQ-032 All-negative vector [-5,-2,-8,-3,-2,-7,-1,-6] -> data_out=-1, idx_out=6 (signed compare verified).
REQ-033 Result ready with m_ready=0 for 5 cycles, then 1 -> m_valid high and outputs unchanged for all 5 cycles, s_ready=0 throughout, and s_valid pulses during the stall are not accepted.
REQ-034 Random s_valid gaps (about 50%) over 100 random vectors, checked against a reference model -> every result matches, with exactly N accepts per result.
REQ-035 Reset pulsed low after 4 accepts and asynchronously between clock edges -> outputs are at reset values immediately; the next 8 accepts form a fresh vector with the correct result.
REQ-036 All-equal vector [0,0,0,0,0,0,0,0] followed immediately by [1..8] -> results (0,0) then (8,7), with no element lost at the vector boundary.
